// File: rtl/matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_scan_driver
//  Description : Scans a pixel frame RAM one row at a time, serialises each
//                W-bit row word MSB-first onto an sdata/sclk/latch shifter
//                interface and drives a one-hot row select for a multiplexed
//                LED matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_driver #(
    parameter int N   = 2,   // RAM address width; 2**N matrix rows
    parameter int W   = 8,   // pixels per row word
    parameter int DIV = 2    // clk cycles per sclk half-period (1..255)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [W-1:0]       ram_data,
    output logic [N-1:0]       ram_addr,
    output logic               ram_rd_active,
    output logic               sdata,
    output logic               sclk,
    output logic               latch,
    output logic [2**N-1:0]    row_sel,
    output logic               frame_done
);

    localparam int c_ROWS = 2**N;
    localparam int c_BW   = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_SHIFT = 3'd3;
    localparam logic [2:0] c_ST_LATCH = 3'd4;

    localparam logic [7:0]        c_DIV_LAST  = 8'(DIV - 1);
    localparam logic [c_BW-1:0]   c_BIT_LAST  = c_BW'(W - 1);
    localparam logic [c_BW-1:0]   c_BIT_ONE   = c_BW'(1);
    localparam logic [N-1:0]      c_ROW_ONE   = N'(1);
    localparam logic [N-1:0]      c_ROW_LAST  = {N{1'b1}};
    localparam logic [c_ROWS-1:0] c_SEL_ONE   = c_ROWS'(1);

    logic [2:0]        r_state;
    logic [N-1:0]      r_row;
    logic [N-1:0]      r_ram_addr;
    logic              r_rd_active;
    logic [W-1:0]      r_shreg;
    logic [c_BW-1:0]   r_bit_cnt;
    logic [7:0]        r_div;
    logic              r_sclk;
    logic              r_latch;
    logic [c_ROWS-1:0] r_row_sel;
    logic              r_frame_done;

    logic [N-1:0]      w_row_next;
    logic [c_ROWS-1:0] w_row_onehot;

    // Next row index (wraps modulo 2**N) and the select pattern for the row being latched
    always_comb begin
        w_row_next   = r_row + c_ROW_ONE;
        w_row_onehot = c_SEL_ONE << r_row;
    end

    // Scan sequencer: fetch, load, shift out bit by bit, latch, advance row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_row        <= '0;
            r_ram_addr   <= '0;
            r_rd_active  <= 1'b0;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_div        <= '0;
            r_sclk       <= 1'b0;
            r_latch      <= 1'b0;
            r_row_sel    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_row     <= '0;
                    r_row_sel <= '0;
                    if (enable) begin
                        r_state     <= c_ST_FETCH;
                        r_ram_addr  <= '0;
                        r_rd_active <= 1'b1;
                    end
                end

                // Address is on the bus this cycle; the synchronous RAM answers next cycle
                c_ST_FETCH: begin
                    r_state <= c_ST_LOAD;
                end

                c_ST_LOAD: begin
                    r_state     <= c_ST_SHIFT;
                    r_rd_active <= 1'b0;
                    r_shreg     <= ram_data;
                    r_bit_cnt   <= c_BIT_LAST;
                    r_div       <= '0;
                    r_sclk      <= 1'b0;
                end

                // Each bit spends DIV cycles with sclk low then DIV cycles high;
                // the shift happens only after the high phase so sdata never
                // moves around the sampling edge.
                c_ST_SHIFT: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit_cnt == '0) begin
                                r_state      <= c_ST_LATCH;
                                r_latch      <= 1'b1;
                                r_frame_done <= (r_row == c_ROW_LAST);
                            end else begin
                                r_shreg   <= r_shreg << 1;
                                r_bit_cnt <= r_bit_cnt - c_BIT_ONE;
                            end
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                // Stopping blanks the display at once and rewinds to row 0,
                // so a restart always begins at the top of the frame.
                c_ST_LATCH: begin
                    r_latch      <= 1'b0;
                    r_frame_done <= 1'b0;
                    if (enable) begin
                        r_state     <= c_ST_FETCH;
                        r_row       <= w_row_next;
                        r_row_sel   <= w_row_onehot;
                        r_ram_addr  <= w_row_next;
                        r_rd_active <= 1'b1;
                    end else begin
                        r_state   <= c_ST_IDLE;
                        r_row     <= '0;
                        r_row_sel <= '0;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ram_addr      = r_ram_addr;
    assign ram_rd_active = r_rd_active;
    assign sdata         = r_shreg[W-1];
    assign sclk          = r_sclk;
    assign latch         = r_latch;
    assign row_sel       = r_row_sel;
    assign frame_done    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_scan_driver
//  Description : Directed self-checking bench for matrix_scan_driver, with a
//                default instance (N=2, W=8, DIV=2) and a small instance
//                (N=1, W=4, DIV=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_driver;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic       reset;
    logic       enable;
    logic [7:0] ram_data;
    logic [1:0] ram_addr;
    logic       ram_rd_active;
    logic       sdata;
    logic       sclk;
    logic       latch;
    logic [3:0] row_sel;
    logic       frame_done;
    logic [7:0] mem [0:3];

    matrix_scan_driver #(.N(2), .W(8), .DIV(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .ram_data      (ram_data),
        .ram_addr      (ram_addr),
        .ram_rd_active (ram_rd_active),
        .sdata         (sdata),
        .sclk          (sclk),
        .latch         (latch),
        .row_sel       (row_sel),
        .frame_done    (frame_done)
    );

    // synchronous RAM, one cycle read latency
    always @(posedge clk) ram_data <= mem[ram_addr];

    // ---------------- small instance ----------------
    logic       s_reset;
    logic       s_enable;
    logic [3:0] s_ram_data;
    logic [0:0] s_ram_addr;
    logic       s_ram_rd_active;
    logic       s_sdata;
    logic       s_sclk;
    logic       s_latch;
    logic [1:0] s_row_sel;
    logic       s_frame_done;
    logic [3:0] s_mem [0:1];

    matrix_scan_driver #(.N(1), .W(4), .DIV(1)) dut_small (
        .clk           (clk),
        .reset         (s_reset),
        .enable        (s_enable),
        .ram_data      (s_ram_data),
        .ram_addr      (s_ram_addr),
        .ram_rd_active (s_ram_rd_active),
        .sdata         (s_sdata),
        .sclk          (s_sclk),
        .latch         (s_latch),
        .row_sel       (s_row_sel),
        .frame_done    (s_frame_done)
    );

    always @(posedge clk) s_ram_data <= s_mem[s_ram_addr];

    // ---------------- capture buffers (index = cycle number) ----------------
    localparam int c_CAP = 400;
    logic       sd_a [0:c_CAP-1];
    logic       sc_a [0:c_CAP-1];
    logic       lt_a [0:c_CAP-1];
    logic       fd_a [0:c_CAP-1];
    logic       rd_a [0:c_CAP-1];
    logic [1:0] ra_a [0:c_CAP-1];
    logic [3:0] rs_a [0:c_CAP-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record cycles 1..n; the caller arranges that the next rising edge is edge 0.
    // ev_kind: 0 none, 1 drop enable, 2 write mem[ev_addr]=ev_data (after sampling cycle ev_cyc)
    task automatic capture(input int n, input int ev_cyc, input int ev_kind,
                           input int ev_addr, input logic [7:0] ev_data);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            sd_a[c] = sdata;
            sc_a[c] = sclk;
            lt_a[c] = latch;
            fd_a[c] = frame_done;
            rd_a[c] = ram_rd_active;
            ra_a[c] = ram_addr;
            rs_a[c] = row_sel;
            if (c == ev_cyc && ev_kind == 1) enable = 1'b0;
            if (c == ev_cyc && ev_kind == 2) mem[ev_addr] = ev_data;
        end
    endtask

    // Reset the default instance, then release it with enable high
    task automatic restart();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    // Serial word of the row whose edge 0 sits at cycle 'base'
    function automatic logic [7:0] word_at(input int base);
        logic [7:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[7-k] = sd_a[base + 5 + 4*k];
        return w;
    endfunction

    initial begin
        int ok;
        int cnt;
        logic [3:0] s_word;

        reset    = 1'b1;
        enable   = 1'b0;
        s_reset  = 1'b1;
        s_enable = 1'b0;
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        s_mem[0] = 4'hB; s_mem[1] = 4'h6;

        // ---------- reset state ----------
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {24'd0, ram_addr, ram_rd_active, sdata, sclk, latch, row_sel, frame_done}, 32'd0);

        // ---------- single row 8'hA5 ----------
        mem[0] = 8'hA5; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
        restart();
        capture(40, 0, 0, 0, 8'h00);
        chk("a5_fetch_cycle1", {ra_a[1], rd_a[1]}, {2'd0, 1'b1});
        chk("a5_rd_active_c2_c3", {rd_a[2], rd_a[3]}, 2'b10);
        chk("a5_word", word_at(0), 8'hA5);
        ok = 0;
        for (int k = 0; k < 8; k++)
            if ({sc_a[3+4*k], sc_a[4+4*k], sc_a[5+4*k], sc_a[6+4*k]} == 4'b0011) ok++;
        chk("a5_sclk_pattern", ok, 8);
        ok = 0;
        for (int k = 0; k < 8; k++)
            if (sd_a[3+4*k] === sd_a[5+4*k] && sd_a[4+4*k] === sd_a[5+4*k] && sd_a[6+4*k] === sd_a[5+4*k]) ok++;
        chk("a5_sdata_stable", ok, 8);
        chk("a5_latch_34_35_36", {lt_a[34], lt_a[35], lt_a[36]}, 3'b010);
        chk("a5_sclk_in_latch", sc_a[35], 1'b0);
        chk("a5_row_sel_35", rs_a[35], 4'b0000);
        chk("a5_row_sel_36", rs_a[36], 4'b0001);
        chk("a5_next_fetch", {ra_a[36], rd_a[36]}, {2'd1, 1'b1});

        // ---------- full frame ----------
        mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hFF; mem[3] = 8'h00;
        restart();
        capture(145, 0, 0, 0, 8'h00);
        chk("frame_word_r0", word_at(0),   8'h01);
        chk("frame_word_r1", word_at(35),  8'h80);
        chk("frame_word_r2", word_at(70),  8'hFF);
        chk("frame_word_r3", word_at(105), 8'h00);
        chk("frame_row_sel_seq", {rs_a[36], rs_a[71], rs_a[106], rs_a[141]}, 16'h1248);
        chk("frame_addr_seq", {ra_a[36], ra_a[71], ra_a[106], ra_a[141]}, 8'b01_10_11_00);
        cnt = 0;
        for (int c = 1; c <= 145; c++) if (fd_a[c] === 1'b1) cnt++;
        chk("frame_done_count", cnt, 1);
        chk("frame_done_c140", fd_a[140], 1'b1);
        cnt = 0;
        for (int c = 1; c <= 140; c++) if (rd_a[c] === 1'b1) cnt++;
        chk("frame_rd_active_cycles", cnt, 8);

        // ---------- enable drop in cycle 10 ----------
        mem[0] = 8'h5A;
        restart();
        capture(45, 10, 1, 0, 8'h00);
        chk("drop_word", word_at(0), 8'h5A);
        chk("drop_latch_35", lt_a[35], 1'b1);
        ok = 0;
        for (int c = 36; c <= 45; c++) if (rd_a[c] === 1'b0 && rs_a[c] === 4'b0000 && lt_a[c] === 1'b0) ok++;
        chk("drop_idle_36_45", ok, 10);
        mem[0] = 8'hC6;
        @(negedge clk);
        enable = 1'b1;
        capture(40, 0, 0, 0, 8'h00);
        chk("reenable_fetch_row0", {ra_a[1], rd_a[1]}, {2'd0, 1'b1});
        chk("reenable_word", word_at(0), 8'hC6);
        chk("reenable_row_sel", rs_a[36], 4'b0001);

        // ---------- mid-row write ----------
        mem[0] = 8'h00; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'h00;
        restart();
        capture(220, 50, 2, 1, 8'hC3);
        chk("midwrite_frame0_row1", word_at(35), 8'h3C);
        chk("midwrite_frame1_row1", word_at(175), 8'hC3);

        // ---------- reset mid-SHIFT with sclk high ----------
        mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'hFF; mem[3] = 8'hFF;
        restart();
        capture(75, 0, 0, 0, 8'h00);
        chk("prereset_sclk_high", {sc_a[75], sd_a[75], ra_a[75]}, {1'b1, 1'b1, 2'd2});
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {24'd0, ram_addr, ram_rd_active, sdata, sclk, latch, row_sel, frame_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        capture(3, 0, 0, 0, 8'h00);
        chk("postreset_fetch_row0", {ra_a[1], rd_a[1], rd_a[3]}, {2'd0, 1'b1, 1'b0});

        // ---------- small instance: N=1, W=4, DIV=1 ----------
        @(negedge clk);
        s_reset  = 1'b0;
        s_enable = 1'b1;
        s_word = '0;
        cnt = 0;
        ok = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            #1;
            if (c == 3 || c == 5) chk("small_sclk_low", s_sclk, 1'b0);
            if (c == 4 || c == 6) chk("small_sclk_high", s_sclk, 1'b1);
            if (c == 4 || c == 6 || c == 8 || c == 10) s_word = {s_word[2:0], s_sdata};
            if (c == 11) chk("small_latch_c11", s_latch, 1'b1);
            if (c == 11) chk("small_word_r0", s_word, 4'hB);
            if (c == 12) chk("small_row_sel_c12", s_row_sel, 2'b01);
            if (c == 22) chk("small_latch_c22", s_latch, 1'b1);
            if (c == 23) chk("small_row_sel_c23", s_row_sel, 2'b10);
            if (c == 23) chk("small_addr_wrap_c23", s_ram_addr, 1'b0);
            if (s_frame_done === 1'b1) begin
                cnt++;
                if (c == 22 || c == 44) ok++;
            end
        end
        chk("small_frame_done_count", cnt, 2);
        chk("small_frame_done_cycles", ok, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_scan_driver.md
# matrix_scan_driver

Downstream consumer of the pixel frame RAM. It continuously scans the RAM one row (one address) at a time and serialises each W-bit row word MSB-first onto a shift-register interface: serial data, shift clock, latch. It also drives a one-hot row select for a multiplexed LED matrix. It owns the RAM address bus only while fetching. The pixel writer owns the RAM at all other times.

## Interface
- N, 2, RAM address width; the matrix has 2**N rows.
- W, 8, row word width, i.e. pixels per row.
- DIV, 2, clk cycles per sclk half-period; legal range 1 to 255.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- enable  in  1  scan enable; level sensitive.
- ram_data  in  W  RAM read data. Synchronous RAM: data is valid the cycle after the address is presented.
- ram_addr  out  N  current row address; registered.
- ram_rd_active  out  1  high during FETCH and LOAD.
  - Top level steers the RAM address to ram_addr and forces read_write=0 while this is high.
- sdata  out  1  serial pixel data, MSB first.
- sclk  out  1  shift clock; the external shifter samples sdata on the sclk rising edge.
- latch  out  1  one-cycle pulse that transfers the shifted word to the outputs.
- row_sel  out  2**N  one-hot active row; all zeros means blanked.
- frame_done  out  1  one-cycle pulse at the end of the last row.

## Operation
- States: IDLE, FETCH, LOAD, SHIFT, LATCH.
- Reset values: state=IDLE, row=0, ram_addr=0, ram_rd_active=0, sdata=0, sclk=0, latch=0, row_sel=0, frame_done=0, shift register=0, bit and divider counters=0.
- IDLE: row=0, row_sel=0. If enable=1, go to FETCH.
- FETCH, 1 cycle: ram_addr=row, ram_rd_active=1.
- LOAD, 1 cycle: ram_rd_active=1. At the exiting edge: shreg <= ram_data, bit counter <= W-1, divider <= 0, sclk=0.
- SHIFT: sdata = shreg[W-1] throughout.
  - sclk is low for DIV cycles, then high for DIV cycles.
  - At the edge ending the high phase: if bit counter=0, go to LATCH; else shift shreg left by 1 (zero fill), decrement the bit counter, sclk <= 0.
- LATCH, 1 cycle: latch=1 and sclk=0.
  - At the exiting edge: row_sel <= 1<<row.
  - If row=2**N-1: frame_done=1 during this cycle, and row wraps to 0.
  - Otherwise row increments.
  - Next state is FETCH if enable=1, else IDLE.
- enable is sampled only in IDLE and LATCH. Deassertion mid-row completes the current row, including the latch pulse, then enters IDLE. IDLE blanks row_sel and resets row to 0, so the next start always begins at row 0.
- RAM contents may change between rows. Each row uses the value read during its own FETCH/LOAD. A mid-row write does not affect a word that is already loaded.
- Arithmetic:
  - row is N bits and wraps modulo 2**N.
  - The divider counter is 8 bits and compares to DIV-1.
  - The bit counter is clog2(W) bits.
- Reset asserted in any state returns everything to the reset values immediately (asynchronous). No partial latch pulse is emitted after reset.

## Timing
- Row period = 3 + 2*DIV*W cycles. Defaults: 35 cycles per row, 140 cycles per frame.
- The edge that sees enable=1 in IDLE is edge 0. Default timeline after it:
  - Cycle 1: FETCH.
  - Cycle 2: LOAD.
  - Cycles 3-34: SHIFT. Bit k (k=0 is the MSB) has sclk low in cycles 3+4k..4+4k and high in cycles 5+4k..6+4k.
  - Cycle 35: LATCH.
  - Cycle 36: next FETCH.
- sdata is stable for the entire 2*DIV cycles of each bit, including across the sclk rising edge.
- row_sel changes on the edge after the latch pulse. The displayed row always matches the most recently latched data.
- ram_rd_active is high in exactly 2 of every row period, which is the RAM read latency of 1 plus 1 cycle of address setup.

## Test plan
- Reset: assert reset mid-SHIFT with sclk=1 -> all outputs return to 0 in the same cycle; after release with enable=1, the first FETCH drives ram_addr=0.
- Single row: row0=8'hA5, defaults -> the sdata values sampled at the 8 sclk rises are 1,0,1,0,0,1,0,1; latch=1 in cycle 35; row_sel=4'b0001 from cycle 36.
- Full frame: rows 8'h01, 8'h80, 8'hFF, 8'h00 -> the serial words match in order; row_sel goes 0001, 0010, 0100, 1000; frame_done pulses once at cycle 140; ram_addr wraps to 0 in cycle 141.
- Enable drop: deassert enable in cycle 10 -> row 0 completes with latch at cycle 35; state is IDLE from cycle 36 with row_sel=0; re-enable -> scanning restarts at row 0.
- Mid-row write: change row1 from 8'h3C to 8'hC3 during row 1 SHIFT -> 8'h3C is shifted this frame and 8'hC3 the next frame.
- Parameters: DIV=1, W=4, N=1 -> row period 11 cycles, sclk period 2 cycles, frame_done every 22 cycles.
